src_pp_loader: RTL
==================

# src_pp_loader

Double-buffered source loader that sits directly upstream of the ping-pong compute controller. It accepts a valid/ready word stream and writes it alternately into source bank 0 and bank 1. It publishes per-bank "full" flags (`src_en[1:0]`), per-bank word counts and the end-of-stream flag (`src_fin`), and it observes the compute-side bank select `p` and the completion pulse `s_fin_in`. It never writes a bank whose `src_en` bit is set.

## Interface
- `DW`, default 32: stream and bank data width.
- `DEPTH`, default 16: words per bank; must be a power of 2, ≥2.
- `AW`, default `$clog2(DEPTH)`: bank address width (derived, not overridden).

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — reset, asynchronous and active-low.
- `run`  in  1  — job enable; low acts as synchronous clear of all job state.
- `src_valid`  in  1  — stream word valid.
- `src_data`  in  DW  — stream word.
- `src_last`  in  1  — final word of job, qualified by `src_valid`.
- `src_ready`  out  1  — loader accepts a word this cycle.
- `p`  in  1  — bank currently owned by compute.
- `s_fin_in`  in  1  — one-cycle pulse: compute finished bank `p`.
- `wr_en`  out  1  — bank write strobe.
- `wr_bank`  out  1  — target bank of the write.
- `wr_addr`  out  AW  — word address within the bank.
- `wr_data`  out  DW  — write data.
- `src_en`  out  2  — bit b high means bank b holds valid data.
- `len0`, `len1`  out  AW+1  — valid word count of bank 0 / bank 1 (1..DEPTH).
- `src_fin`  out  1  — sticky: last stream word has been written.

## Operation
- States:
  - IDLE: `run` low or just raised.
  - WAIT: waiting for the next bank to free.
  - FILL: accepting words.
  - DONE: stream finished.
- `fill_bank` is a register holding the bank being filled. `next_bank` resets to 0, because `p` resets to 1 and bank 0 is the first free bank.
- IDLE→WAIT when `run`=1.
- WAIT→FILL when `src_en[next_bank]`=0. On that transition, latch `fill_bank`=`next_bank` and clear `addr`.
- FILL:
  - `src_ready` = 1.
  - Each handshake writes `src_data` to (`fill_bank`, `addr`) and increments `addr`.
- Bank close occurs on the handshake with `addr`=DEPTH-1 or with `src_last`=1. On close:
  - set `src_en[fill_bank]`;
  - set `len[fill_bank]` = `addr`+1;
  - set `next_bank` = ~`fill_bank`;
  - go to WAIT, or to DONE if `src_last`.
- DONE: `src_fin`=1 and `src_ready`=0 until `run` falls.
- Clearing `src_en[b]`: on `s_fin_in`=1 with `p`=b. A set and a clear on different banks in the same cycle both take effect. A set and a clear on the same bank is a protocol violation; in that case the set wins.
- `fill_bank` stays latched through the fill. A toggle of `p` mid-fill does not redirect writes.
- `run` low, at any state or mid-fill:
  - next cycle: IDLE, `src_en`=0, `src_fin`=0, `next_bank`=0, `addr`=0;
  - `len0`/`len1` hold their values;
  - no write is issued.

## Timing
- Reset values (async, `rst_n`=0):
  - state IDLE;
  - `src_ready`=0, `wr_en`=0, `wr_bank`=0, `wr_addr`=0, `wr_data`=0;
  - `src_en`=2'b00, `len0`=`len1`=0, `src_fin`=0.
- `src_ready` is a registered/state-decoded output; it is not a function of `src_valid`.
- Write port is registered. A handshake in cycle N gives `wr_en`=1 in cycle N+1 with the matching bank/addr/data.
- `src_en`, `len` and `src_fin` update in cycle N+1 after the closing handshake, aligned with the final `wr_en`.
- `src_ready` drops in N+1 after close.
- Minimum bubble between banks: 1 cycle (WAIT) when the next bank is already free.
- Throughput: 1 word/cycle within a bank.
- `addr` never wraps. Close at DEPTH-1 is mandatory, so `len`≤DEPTH.

## Structure
- Package `src_pkg` holds:
  - the state enum type (IDLE/WAIT/FILL/DONE);
  - default `DW`/`DEPTH` constants;
  - bank-index typedef `bank_t` (logic).
- Sub-module `bank_flags` owns `src_en[1:0]` and `len0`/`len1` set/clear arbitration.
- Bank RAMs are external; this block drives only the write port.

## Test plan
- DEPTH=4, 10 words with `last` on word 10, compute pulses `s_fin_in` 3 cycles after each `src_en` rise:
  - banks close 0,1,0;
  - `len0`=4, `len1`=4, final `len0`=2;
  - `src_fin`=1 one cycle after word 10 is accepted.
- DEPTH=4, 9 words, no `s_fin_in` at all:
  - `src_en`=2'b11 after 8 words;
  - `src_ready` stays 0 and word 9 is held.
  - A single `s_fin_in` with `p`=0 clears bit 0; WAIT→FILL follows; word 9 is written to bank 0 with `len0`=1.
- Single-word job (`last` on word 1):
  - `wr_en` at N+1, bank 0, addr 0;
  - `src_en`=2'b01, `len0`=1, `src_fin`=1 in N+1.
- Same-cycle close of bank 1 and `s_fin_in` with `p`=0:
  - next cycle `src_en`=2'b10;
  - `len1` correct.
- `run` dropped mid-fill at addr 2:
  - next cycle no `wr_en`, `src_en`=0, `src_fin`=0, state IDLE.
  - After `run` re-rises, filling restarts in bank 0 at addr 0.
- Assert `rst_n` low asynchronously mid-fill:
  - all outputs take reset values immediately, without a clock edge.

Source files
------------

// File: rtl/src_pp_loader_pkg.sv
// Shared types and defaults for the ping-pong source loader.
package src_pkg;
  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 16;

  typedef logic bank_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_FILL,
    S_DONE
  } state_t;
endpackage

// File: rtl/src_pp_loader_bank_flags.sv
// Per-bank full flags and word counts; set from the fill side, cleared by compute.
module bank_flags
  import src_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        set_vld,
  input  bank_t       set_bank,
  input  logic [AW:0] set_len,
  input  logic        fin,
  input  bank_t       p,
  output logic [1:0]  src_en,
  output logic [AW:0] len0,
  output logic [AW:0] len1
);
  logic [1:0][AW:0] len;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic        set_b, clr_b, en_q;
    logic [AW:0] len_q;

    assign set_b = set_vld && (set_bank == bank_t'(b));
    assign clr_b = fin && (p == bank_t'(b));

    // A set and a clear on the same bank can only come from a misbehaving
    // compute side; keeping the data marked full is the safe outcome.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        en_q  <= 1'b0;
        len_q <= '0;
      end else begin
        if (clr)        en_q <= 1'b0;
        else if (set_b) en_q <= 1'b1;
        else if (clr_b) en_q <= 1'b0;
        if (set_b && !clr) len_q <= set_len;
      end
    end

    assign src_en[b] = en_q;
    assign len[b]    = len_q;
  end

  assign len0 = len[0];
  assign len1 = len[1];
endmodule

// File: rtl/src_pp_loader.sv
// Double-buffered source loader: streams words alternately into two banks
// and hands full banks to the ping-pong compute controller.
module src_pp_loader
  import src_pkg::*;
#(
  parameter int  DW    = DW_DEF,
  parameter int  DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          src_valid,
  input  logic [DW-1:0] src_data,
  input  logic          src_last,
  output logic          src_ready,
  input  logic          p,
  input  logic          s_fin_in,
  output logic          wr_en,
  output logic          wr_bank,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [1:0]    src_en,
  output logic [AW:0]   len0,
  output logic [AW:0]   len1,
  output logic          src_fin
);
  localparam logic [AW-1:0] ADDR_MAX = AW'(DEPTH - 1);

  state_t        state, state_nxt;
  bank_t         fill_bank, next_bank;
  logic [AW-1:0] addr;
  logic          hs, close_hs;
  logic [AW:0]   close_len;

  assign hs        = src_valid && src_ready;
  assign close_hs  = hs && (src_last || (addr == ADDR_MAX));
  assign close_len = {1'b0, addr} + (AW+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!run) state_nxt = S_IDLE;
    else begin
      case (state)
        S_IDLE:  state_nxt = S_WAIT;
        S_WAIT:  if (!src_en[next_bank]) state_nxt = S_FILL;
        S_FILL:  if (close_hs) state_nxt = src_last ? S_DONE : S_WAIT;
        S_DONE:  state_nxt = S_DONE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Gated by run so a word offered in the cycle run drops is never taken.
  always_comb begin
    src_ready = 1'b0;
    if (run && state == S_FILL) src_ready = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_bank <= 1'b0;
      next_bank <= 1'b0;
      addr      <= '0;
      wr_en     <= 1'b0;
      wr_bank   <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      src_fin   <= 1'b0;
    end else if (!run) begin
      next_bank <= 1'b0;
      addr      <= '0;
      wr_en     <= 1'b0;
      src_fin   <= 1'b0;
    end else begin
      wr_en <= hs;
      if (state == S_WAIT && state_nxt == S_FILL) begin
        fill_bank <= next_bank;
        addr      <= '0;
      end
      if (hs) begin
        wr_bank <= fill_bank;
        wr_addr <= addr;
        wr_data <= src_data;
        addr    <= close_hs ? '0 : addr + AW'(1);
      end
      if (close_hs) begin
        next_bank <= ~fill_bank;
        if (src_last) src_fin <= 1'b1;
      end
    end
  end

  bank_flags #(.AW(AW)) u_flags (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (!run),
    .set_vld  (close_hs),
    .set_bank (fill_bank),
    .set_len  (close_len),
    .fin      (s_fin_in),
    .p        (p),
    .src_en   (src_en),
    .len0     (len0),
    .len1     (len1)
  );
endmodule
